// File: rtl/gmii_rx_framer_if.sv
// GMII receive stream in, framed payload stream out.
// The PHY-facing side drives rxd/rxdv/rxer. The framer drives the payload and status side.
interface gmii_rx_framer_if;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxer;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] out_len;
  logic        out_crc_err;
  logic        out_phy_err;
  logic        out_len_err;
  logic [15:0] cnt_good;
  logic [15:0] cnt_bad;

  modport master (
    output rxd, rxdv, rxer,
    input  out_data, out_valid, out_sof, out_eof, out_len,
    input  out_crc_err, out_phy_err, out_len_err, cnt_good, cnt_bad
  );

  modport slave (
    input  rxd, rxdv, rxer,
    output out_data, out_valid, out_sof, out_eof, out_len,
    output out_crc_err, out_phy_err, out_len_err, cnt_good, cnt_bad
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer.
// It strips the preamble and SFD, then delays data through a 5-byte pipeline.
// That delay lets the 4 FCS bytes be dropped at frame end without lookahead.
// It also checks CRC-32 and frame length, and keeps good/bad frame counters.
module gmii_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input logic clk,
  input logic rstn,
  gmii_rx_framer_if.slave bus
);

  localparam logic [15:0] MinLen     = 16'(MIN_FRAME);
  localparam logic [15:0] MaxLen     = 16'(MAX_FRAME);
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  typedef enum logic [1:0] {DROP, IDLE, PRE, DATA} state_t;

  state_t          state_q;
  logic [4:0][7:0] pipe_q;
  logic [31:0]     crc_q;
  logic [31:0]     crc_d;
  logic [15:0]     len_q;
  logic [15:0]     len_d;
  logic            phy_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            sof_q;
  logic            eof_q;
  logic [15:0]     outLen_q;
  logic            crcErr_q;
  logic            phyErr_q;
  logic            lenErr_q;
  logic [15:0]     good_q;
  logic [15:0]     bad_q;
  logic            crcBad;
  logic            lenBad;
  logic            pipeFull;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_d    = crcByte(crc_q, bus.rxd);
  assign len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  // Running the CRC over data plus FCS leaves a fixed residue when the FCS is correct.
  assign crcBad   = (crc_q != CrcResidue);
  assign lenBad   = (len_q < MinLen) || (len_q > MaxLen);
  // Once 5 bytes are buffered, the oldest one is guaranteed to be payload.
  assign pipeFull = (len_q >= 16'd5);

  assign bus.out_data    = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_sof     = sof_q;
  assign bus.out_eof     = eof_q;
  assign bus.out_len     = outLen_q;
  assign bus.out_crc_err = crcErr_q;
  assign bus.out_phy_err = phyErr_q;
  assign bus.out_len_err = lenErr_q;
  assign bus.cnt_good    = good_q;
  assign bus.cnt_bad     = bad_q;

  // Framing FSM, byte pipeline, CRC/length tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= DROP;
      pipe_q   <= '0;
      crc_q    <= '1;
      len_q    <= '0;
      phy_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      outLen_q <= '0;
      crcErr_q <= 1'b0;
      phyErr_q <= 1'b0;
      lenErr_q <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      outLen_q <= '0;
      crcErr_q <= 1'b0;
      phyErr_q <= 1'b0;
      lenErr_q <= 1'b0;
      case (state_q)
        DROP: begin
          if (!bus.rxdv) state_q <= IDLE;
        end
        IDLE, PRE: begin
          if (!bus.rxdv) begin
            state_q <= IDLE;
            if (state_q == PRE) bad_q <= bad_q + 16'd1;
          end else if (bus.rxd == 8'h55) begin
            state_q <= PRE;
          end else if (bus.rxd == 8'hD5) begin
            state_q <= DATA;
            crc_q   <= '1;
            len_q   <= '0;
            phy_q   <= 1'b0;
          end else begin
            state_q <= DROP;
            bad_q   <= bad_q + 16'd1;
          end
        end
        DATA: begin
          if (bus.rxdv) begin
            pipe_q <= {pipe_q[3:0], bus.rxd};
            crc_q  <= crc_d;
            len_q  <= len_d;
            if (bus.rxer) phy_q <= 1'b1;
            if (pipeFull) begin
              data_q  <= pipe_q[4];
              valid_q <= 1'b1;
              sof_q   <= (len_q == 16'd5);
            end
          end else begin
            state_q <= IDLE;
            if (pipeFull) begin
              data_q   <= pipe_q[4];
              valid_q  <= 1'b1;
              sof_q    <= (len_q == 16'd5);
              eof_q    <= 1'b1;
              outLen_q <= len_q;
              crcErr_q <= crcBad;
              phyErr_q <= phy_q;
              lenErr_q <= lenBad;
              if (crcBad || phy_q || lenBad) bad_q  <= bad_q + 16'd1;
              else                           good_q <= good_q + 16'd1;
            end else begin
              bad_q <= bad_q + 16'd1;
            end
          end
        end
        default: state_q <= DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Testbench for gmii_rx_framer.
// A reference model parses each raw GMII frame as a byte list, without any state machine.
// It predicts every emitted byte and the clock edge that byte should appear on.
module tb_gmii_rx_framer;

  typedef logic [7:0] byteQ_t[$];

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eof;
    int         len;
    bit         crcErr;
    bit         phyErr;
    bit         lenErr;
    int         edgeAt;
  } exp_t;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  int     errors = 0;
  int     checks = 0;
  int     edgeNum = 0;
  int     goodModel = 0;
  int     badModel = 0;
  bit     monitorOn = 1'b0;
  exp_t   expQ[$];
  exp_t   e;

  gmii_rx_framer_if bus();

  gmii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 100 MHz receive clock.
  always #5 clk = ~clk;

  // Count active edges so predicted output times can be compared against them.
  always @(posedge clk) edgeNum <= edgeNum + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edgeNum);
    end
  endtask

  // Compute the standard Ethernet FCS: reflected CRC-32, final value complemented.
  function automatic logic [31:0] fcsOf(input byteQ_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Build the full frame: preamble, SFD, body, then the FCS sent LSB byte first.
  function automatic byteQ_t makeFrame(input int pre, input byteQ_t body);
    byteQ_t r;
    logic [31:0] f;
    r = {};
    for (int i = 0; i < pre; i++) r.push_back(8'h55);
    r.push_back(8'hD5);
    foreach (body[i]) r.push_back(body[i]);
    f = fcsOf(body, body.size());
    for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
    return r;
  endfunction

  // Drive one receive cycle, then return 1 ns after the edge that samples it.
  task automatic applyStimulus(input logic [7:0] d, input logic dv, input logic er);
    bus.rxd  = d;
    bus.rxdv = dv;
    bus.rxer = er;
    @(posedge clk);
    #1;
  endtask

  // Predict a frame's outcome from the byte list, drive it, then check the counters after the gap.
  task automatic runFrame(input byteQ_t raw, input int erPos, input int gap);
    int     start;
    int     p;
    int     n;
    bit     crcE;
    bit     phyE;
    bit     lenE;
    byteQ_t pay;
    exp_t   x;
    start = edgeNum + 1;
    p = 0;
    while (p < raw.size() && raw[p] == 8'h55) p++;
    if (p >= raw.size() || raw[p] != 8'hD5) begin
      badModel++;
    end else begin
      pay = {};
      for (int i = p + 1; i < raw.size(); i++) pay.push_back(raw[i]);
      n = pay.size();
      if (n < 5) begin
        badModel++;
      end else begin
        crcE = (fcsOf(pay, n - 4) != {pay[n-1], pay[n-2], pay[n-3], pay[n-4]});
        phyE = (erPos > p);
        lenE = (n < 64) || (n > 1518);
        for (int k = 0; k <= n - 5; k++) begin
          x.data   = pay[k];
          x.sof    = (k == 0);
          x.eof    = (k == n - 5);
          x.len    = (n > 65535) ? 65535 : n;
          x.crcErr = crcE;
          x.phyErr = phyE;
          x.lenErr = lenE;
          x.edgeAt = start + p + 1 + k + 5;
          expQ.push_back(x);
        end
        if (crcE || phyE || lenE) badModel++;
        else                      goodModel++;
      end
    end
    for (int i = 0; i < raw.size(); i++) applyStimulus(raw[i], 1'b1, 1'(i == erPos));
    for (int i = 0; i < gap; i++) applyStimulus(8'($urandom), 1'b0, 1'($urandom));
    checkOutput("cnt_good", 32'(bus.cnt_good), 32'(goodModel));
    checkOutput("cnt_bad", 32'(bus.cnt_bad), 32'(badModel));
  endtask

  // Scoreboard: match every out_valid against the prediction for this edge, and flag outputs nobody expected.
  always @(negedge clk) begin
    if (monitorOn) begin
      while (expQ.size() > 0 && expQ[0].edgeAt < edgeNum) begin
        checkOutput("missing_byte", 32'(0), 32'(1));
        void'(expQ.pop_front());
      end
      if (expQ.size() > 0 && expQ[0].edgeAt == edgeNum) begin
        e = expQ.pop_front();
        checkOutput("out_valid", 32'(bus.out_valid), 32'(1));
        checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
        checkOutput("out_sof", 32'(bus.out_sof), 32'(e.sof));
        checkOutput("out_eof", 32'(bus.out_eof), 32'(e.eof));
        if (e.eof) begin
          checkOutput("out_len", 32'(bus.out_len), 32'(e.len));
          checkOutput("out_crc_err", 32'(bus.out_crc_err), 32'(e.crcErr));
          checkOutput("out_phy_err", 32'(bus.out_phy_err), 32'(e.phyErr));
          checkOutput("out_len_err", 32'(bus.out_len_err), 32'(e.lenErr));
        end
      end else if (bus.out_valid) begin
        checkOutput("spurious_valid", 32'(bus.out_valid), 32'(0));
      end
    end
  end

  // Directed scenarios, then randomized frames, then drain and summarize.
  initial begin
    byteQ_t body;
    byteQ_t raw;
    int     pre;
    int     blen;
    int     er;

    bus.rxd  = 8'h00;
    bus.rxdv = 1'b0;
    bus.rxer = 1'b0;
    rstn     = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("reset_data", 32'(bus.out_data), 32'(0));
    checkOutput("reset_good", 32'(bus.cnt_good), 32'(0));
    checkOutput("reset_bad", 32'(bus.cnt_bad), 32'(0));
    rstn = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    monitorOn = 1'b1;

    // Good 64-byte frame with an incrementing payload.
    body = {};
    for (int i = 0; i < 60; i++) body.push_back(8'(i));
    runFrame(makeFrame(7, body), -1, 1);

    // The same frame with payload byte 10 corrupted after the FCS was computed.
    raw = makeFrame(7, body);
    raw[8 + 10] = raw[8 + 10] ^ 8'h01;
    runFrame(raw, -1, 1);

    // rxer raised on payload byte 16.
    runFrame(makeFrame(7, body), 8 + 16, 1);

    // Bad preamble byte, then a good frame after one idle cycle.
    raw = makeFrame(7, body);
    raw[2] = 8'h5A;
    runFrame(raw, -1, 1);
    runFrame(makeFrame(7, body), -1, 1);

    // A runt of 3 bytes after SFD, then a short but CRC-correct 40-byte frame.
    raw = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
    runFrame(raw, -1, 1);
    body = {};
    for (int i = 0; i < 36; i++) body.push_back(8'($urandom));
    runFrame(makeFrame(7, body), -1, 1);

    // Exactly 5 bytes after SFD, so the same byte carries both sof and eof.
    runFrame(makeFrame(3, {8'hA5}), -1, 1);

    // Reset pulse mid-frame: the rest of the frame must be dropped and the counters cleared.
    body = {};
    for (int i = 0; i < 60; i++) body.push_back(8'($urandom));
    raw = makeFrame(7, body);
    for (int i = 0; i < 11; i++) applyStimulus(raw[i], 1'b1, 1'b0);
    rstn = 1'b0;
    applyStimulus(raw[11], 1'b1, 1'b0);
    rstn = 1'b1;
    goodModel = 0;
    badModel  = 0;
    checkOutput("midreset_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("midreset_eof", 32'(bus.out_eof), 32'(0));
    checkOutput("midreset_len", 32'(bus.out_len), 32'(0));
    checkOutput("midreset_good", 32'(bus.cnt_good), 32'(0));
    checkOutput("midreset_bad", 32'(bus.cnt_bad), 32'(0));
    for (int i = 12; i < raw.size(); i++) applyStimulus(raw[i], 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    runFrame(makeFrame(7, body), -1, 1);

    // Randomized frames with random preamble length, gaps, corruption and rxer.
    for (int f = 0; f < 25; f++) begin
      pre  = $urandom_range(0, 8);
      blen = $urandom_range(1, 90);
      body = {};
      for (int i = 0; i < blen; i++) body.push_back(8'($urandom));
      raw = makeFrame(pre, body);
      if ($urandom_range(0, 4) == 0) begin
        er = pre + 1 + $urandom_range(0, blen + 3);
        raw[er] = raw[er] ^ 8'($urandom_range(1, 255));
      end
      er = ($urandom_range(0, 5) == 0) ? $urandom_range(0, raw.size() - 1) : -1;
      if (pre > 0 && $urandom_range(0, 7) == 0) raw[$urandom_range(0, pre - 1)] = 8'h3C;
      runFrame(raw, er, $urandom_range(1, 3));
    end

    // Oversize frame of 1520 bytes: passed through in full but flagged as a length error.
    body = {};
    for (int i = 0; i < 1516; i++) body.push_back(8'($urandom));
    runFrame(makeFrame(7, body), -1, 2);

    for (int i = 0; i < 8; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
